// File: rtl/vga_sync_gen.sv
// VGA timing generator: counts pixels/lines on rising edges of the divider's dclk,
// sampled as data in the master clock domain, and emits registered sync/blank/strobe outputs.
module vga_sync_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          dclk,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          pix_tick,
  output logic          frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_VIS_C = CW'(H_VIS);
  localparam logic [CW-1:0] V_VIS_C = CW'(V_VIS);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_VIS + V_FP + V_SYNC - 1);

  function automatic logic hsync_f(input logic [CW-1:0] h);
    return !((h >= HS_BEG) && (h <= HS_END));
  endfunction

  function automatic logic vsync_f(input logic [CW-1:0] v);
    return !((v >= VS_BEG) && (v <= VS_END));
  endfunction

  function automatic logic video_f(input logic [CW-1:0] h, input logic [CW-1:0] v);
    return (h < H_VIS_C) && (v < V_VIS_C);
  endfunction

  logic          dclk_q;
  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic          hsync_q, vsync_q, video_on_q;
  logic          pix_tick_q, frame_start_q;
  logic          tick;

  // Next raster position, committed only on a pixel tick
  always_comb begin
    tick = dclk & ~dclk_q;
    hc_d = hc_q;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
    end else begin
      hc_d = hc_q + CW'(1);
    end
  end

  // dclk_q resets high so a dclk already high at release is not taken as an edge
  always_ff @(posedge clk) begin
    if (!clr) begin
      dclk_q        <= 1'b1;
      hc_q          <= H_LAST;
      vc_q          <= V_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      pix_tick_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      dclk_q        <= dclk;
      pix_tick_q    <= tick;
      frame_start_q <= tick && (hc_d == '0) && (vc_d == '0);
      if (tick) begin
        hc_q       <= hc_d;
        vc_q       <= vc_d;
        hsync_q    <= hsync_f(hc_d);
        vsync_q    <= vsync_f(vc_d);
        video_on_q <= video_f(hc_d, vc_d);
      end
    end
  end

  assign hc          = hc_q;
  assign vc          = vc_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pix_tick    = pix_tick_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default 640x480 timing plus a tiny 8x6 raster instance.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       clr, dclk;
  logic [9:0] hc, vc;
  logic       hsync, vsync, video_on, pix_tick, frame_start;

  logic       clr2, dclk2;
  logic [3:0] hc2, vc2;
  logic       hs2, vs2, von2, pt2, fs2;

  vga_sync_gen dut (
    .clk(clk), .clr(clr), .dclk(dclk), .hc(hc), .vc(vc),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pix_tick(pix_tick), .frame_start(frame_start)
  );

  vga_sync_gen #(
    .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CW(4)
  ) dut_small (
    .clk(clk), .clr(clr2), .dclk(dclk2), .hc(hc2), .vc(vc2),
    .hsync(hs2), .vsync(vs2), .video_on(von2),
    .pix_tick(pt2), .frame_start(fs2)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packed view {hc, vc, hsync, vsync, video_on, pix_tick, frame_start}
  function automatic logic [31:0] pk(input logic [9:0] h, input logic [9:0] v,
                                     input logic hs, input logic vs, input logic von,
                                     input logic pt, input logic fs);
    return {7'b0, h, v, hs, vs, von, pt, fs};
  endfunction

  function automatic logic [31:0] dut_pk();
    return pk(hc, vc, hsync, vsync, video_on, pix_tick, frame_start);
  endfunction

  function automatic logic [31:0] small_pk();
    return pk({6'b0, hc2}, {6'b0, vc2}, hs2, vs2, von2, pt2, fs2);
  endfunction

  typedef struct {
    logic       clr;
    logic       dclk;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       hs, vs, von, pt, fs;
  } vec_t;

  vec_t tbl[14];

  task automatic setv(input int i, input logic c, input logic d, input logic [9:0] h,
                      input logic [9:0] v, input logic hs, input logic vs,
                      input logic von, input logic pt, input logic fs);
    tbl[i].clr = c;  tbl[i].dclk = d;
    tbl[i].hc  = h;  tbl[i].vc   = v;
    tbl[i].hs  = hs; tbl[i].vs   = vs; tbl[i].von = von;
    tbl[i].pt  = pt; tbl[i].fs   = fs;
  endtask

  // One pixel period with dclk toggling every 2 clk; snap holds outputs in the tick cycle
  task automatic pix_step(output logic [31:0] snap);
    dclk = 1'b1;
    @(posedge clk); #1;
    snap = dut_pk();
    @(posedge clk); #1;
    check("tick_one_cycle", {30'b0, pix_tick, frame_start}, 32'd0);
    dclk = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  logic [31:0] snap;
  int mh, mv, fs_cnt;

  initial begin
    clr = 1'b0; dclk = 1'b0;
    clr2 = 1'b0; dclk2 = 1'b0;

    setv( 0, 0, 0, 799, 524, 1, 1, 0, 0, 0);
    setv( 1, 0, 1, 799, 524, 1, 1, 0, 0, 0);
    setv( 2, 1, 1, 799, 524, 1, 1, 0, 0, 0);
    setv( 3, 1, 0, 799, 524, 1, 1, 0, 0, 0);
    setv( 4, 1, 0, 799, 524, 1, 1, 0, 0, 0);
    setv( 5, 1, 1,   0,   0, 1, 1, 1, 1, 1);
    setv( 6, 1, 1,   0,   0, 1, 1, 1, 0, 0);
    setv( 7, 1, 0,   0,   0, 1, 1, 1, 0, 0);
    setv( 8, 1, 0,   0,   0, 1, 1, 1, 0, 0);
    setv( 9, 1, 1,   1,   0, 1, 1, 1, 1, 0);
    setv(10, 1, 1,   1,   0, 1, 1, 1, 0, 0);
    setv(11, 1, 0,   1,   0, 1, 1, 1, 0, 0);
    setv(12, 1, 1,   2,   0, 1, 1, 1, 1, 0);
    setv(13, 0, 1, 799, 524, 1, 1, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      clr  = tbl[i].clr;
      dclk = tbl[i].dclk;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), dut_pk(),
            pk(tbl[i].hc, tbl[i].vc, tbl[i].hs, tbl[i].vs, tbl[i].von, tbl[i].pt, tbl[i].fs));
    end

    // dclk held high through reset release, then constant for 100 clk
    clr = 1'b0; dclk = 1'b1;
    @(posedge clk); #1;
    clr = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      check("stall_no_tick", {30'b0, pix_tick, frame_start}, 32'd0);
    end
    check("stall_hold", dut_pk(), pk(799, 524, 1, 1, 0, 0, 0));
    dclk = 1'b0;
    @(posedge clk); #1;
    dclk = 1'b1;
    @(posedge clk); #1;
    check("first_tick", dut_pk(), pk(0, 0, 1, 1, 1, 1, 1));
    @(posedge clk); #1;
    dclk = 1'b0;
    @(posedge clk); #1;

    // One full line plus 300 pixels, against an independent raster model
    mh = 0; mv = 0;
    for (int i = 0; i < 1100; i++) begin
      if (mh == 799) begin
        mh = 0;
        mv = (mv == 524) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      pix_step(snap);
      check($sformatf("line_px%0d", i), snap,
            pk(10'(mh), 10'(mv), !(mh >= 656 && mh <= 751), !(mv >= 490 && mv <= 491),
               (mh < 640 && mv < 480), 1'b1, (mh == 0 && mv == 0)));
    end
    check("line_pos", {12'b0, hc, vc}, {12'b0, 10'd300, 10'd1});

    // Reset coincident with a tick mid-line
    clr = 1'b0; dclk = 1'b1;
    @(posedge clk); #1;
    check("reset_vs_tick", dut_pk(), pk(799, 524, 1, 1, 0, 0, 0));
    clr = 1'b1;
    @(posedge clk); #1;
    check("reset_no_spurious", dut_pk(), pk(799, 524, 1, 1, 0, 0, 0));
    dclk = 1'b0;

    // Tiny raster: H_TOT=8, V_TOT=6, ticks every 2 clk
    clr2 = 1'b0;
    @(posedge clk); #1;
    check("small_reset", small_pk(), pk(7, 5, 1, 1, 0, 0, 0));
    clr2 = 1'b1;
    @(posedge clk); #1;
    mh = 7; mv = 5; fs_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (mh == 7) begin
        mh = 0;
        mv = (mv == 5) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      dclk2 = 1'b1;
      @(posedge clk); #1;
      if (fs2 === 1'b1) fs_cnt++;
      check($sformatf("small_px%0d", i), small_pk(),
            pk(10'(mh), 10'(mv), !(mh >= 5 && mh <= 6), !(mv == 4),
               (mh < 4 && mv < 3), 1'b1, (mh == 0 && mv == 0)));
      dclk2 = 1'b0;
      @(posedge clk); #1;
      check("small_tick_one_cycle", {30'b0, pt2, fs2}, 32'd0);
    end
    check("small_frame_count", 32'(fs_cnt), 32'd3);

    clr2 = 1'b0; dclk2 = 1'b1;
    @(posedge clk); #1;
    check("small_reset_vs_tick", small_pk(), pk(7, 5, 1, 1, 0, 0, 0));
    clr2 = 1'b1; dclk2 = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
